// File: rtl/pattern_round_ctrl.sv
// Round sequencer for the LED pattern-memory game: shows the target, collects a guess,
// drives the lock/unlock comparator handshake and tracks level, lives and game status.
module pattern_round_ctrl #(
  parameter int unsigned SHOW_CYCLES  = 8,
  parameter int unsigned INPUT_CYCLES = 32,
  parameter int unsigned MAX_LIVES    = 3,
  parameter int unsigned LEVELS       = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        btn_valid_i,
  input  logic [15:0] btn_pattern_i,
  output logic [3:0]  pat_addr_o,
  input  logic [15:0] pat_data_i,
  output logic        cmp_enable_o,
  output logic [15:0] cmp_amp_o,
  output logic [15:0] cmp_bmp_o,
  input  logic        cmp_is_equal_i,
  output logic [15:0] led_o,
  output logic [3:0]  level_o,
  output logic [1:0]  lives_o,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic        result_pass_o,
  output logic        game_won_o,
  output logic        game_over_o
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StFetch  = 4'd1;
  localparam logic [3:0] StShow   = 4'd2;
  localparam logic [3:0] StWaitIn = 4'd3;
  localparam logic [3:0] StCmp1   = 4'd4;
  localparam logic [3:0] StGap    = 4'd5;
  localparam logic [3:0] StCmp2   = 4'd6;
  localparam logic [3:0] StCapt   = 4'd7;
  localparam logic [3:0] StJudge  = 4'd8;
  localparam logic [3:0] StWin    = 4'd9;
  localparam logic [3:0] StOver   = 4'd10;

  localparam int unsigned CntMax = (SHOW_CYCLES > INPUT_CYCLES) ? SHOW_CYCLES : INPUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic [3:0]      state_q, state_d;
  logic [3:0]      level_q, level_d;
  logic [1:0]      lives_q, lives_d;
  logic [15:0]     target_q, target_d;
  logic [15:0]     guess_q, guess_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic            result_pass_q, result_pass_d;

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    lives_d       = lives_q;
    target_d      = target_q;
    guess_d       = guess_q;
    cnt_d         = cnt_q;
    pass_d        = pass_q;
    result_pass_d = result_pass_q;
    case (state_q)
      StIdle, StWin, StOver: begin
        if (start_i) begin
          level_d       = 4'd0;
          lives_d       = 2'(MAX_LIVES);
          result_pass_d = 1'b0;
          cnt_d         = '0;
          state_d       = StFetch;
        end
      end
      StFetch: begin
        target_d = pat_data_i;
        cnt_d    = '0;
        state_d  = StShow;
      end
      StShow: begin
        if (cnt_q == CntW'(SHOW_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StWaitIn;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitIn: begin
        // A strobe on the expiry cycle still counts: the guess takes priority.
        if (btn_valid_i) begin
          guess_d = btn_pattern_i;
          cnt_d   = '0;
          state_d = StCmp1;
        end else if (cnt_q == CntW'(INPUT_CYCLES)) begin
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = StJudge;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCmp1: state_d = StGap;
      StGap:  state_d = StCmp2;
      StCmp2: state_d = StCapt;
      StCapt: begin
        pass_d  = cmp_is_equal_i;
        state_d = StJudge;
      end
      StJudge: begin
        result_pass_d = pass_q;
        if (pass_q) begin
          if (level_q == 4'(LEVELS - 1)) begin
            state_d = StWin;
          end else begin
            level_d = level_q + 4'd1;
            state_d = StFetch;
          end
        end else if (lives_q <= 2'd1) begin
          lives_d = 2'd0;
          state_d = StOver;
        end else begin
          lives_d = lives_q - 2'd1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      level_q       <= 4'd0;
      lives_q       <= 2'(MAX_LIVES);
      target_q      <= 16'd0;
      guess_q       <= 16'd0;
      cnt_q         <= '0;
      pass_q        <= 1'b0;
      result_pass_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      target_q      <= target_d;
      guess_q       <= guess_d;
      cnt_q         <= cnt_d;
      pass_q        <= pass_d;
      result_pass_q <= result_pass_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them (and unlocks the
  // comparator) in the same cycle.
  always_comb begin
    pat_addr_o     = level_q;
    level_o        = level_q;
    lives_o        = lives_q;
    cmp_amp_o      = target_q;
    cmp_bmp_o      = guess_q;
    cmp_enable_o   = (state_q == StCmp1) || (state_q == StCmp2);
    led_o          = (state_q == StShow) ? target_q : 16'd0;
    busy_o         = !((state_q == StIdle) || (state_q == StWin) || (state_q == StOver));
    result_valid_o = (state_q == StJudge);
    result_pass_o  = (state_q == StJudge) ? pass_q : result_pass_q;
    game_won_o     = (state_q == StWin);
    game_over_o    = (state_q == StOver);
  end

endmodule

// File: tb/tb_pattern_round_ctrl.sv
// Randomized bench for pattern_round_ctrl: a driver plays rounds from a game-level model and
// queues expected verdicts; a monitor pops and compares on every result_valid pulse.
module tb_pattern_round_ctrl;

  localparam int S  = 8;
  localparam int I  = 32;
  localparam int ML = 3;
  localparam int L  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, btn_valid;
  logic [15:0] btn_pattern;
  logic [3:0]  pat_addr;
  logic [15:0] pat_data;
  logic        cmp_enable;
  logic [15:0] cmp_amp, cmp_bmp;
  logic        cmp_is_equal;
  logic [15:0] led;
  logic [3:0]  level;
  logic [1:0]  lives;
  logic        busy, result_valid, result_pass, game_won, game_over;

  pattern_round_ctrl #(
    .SHOW_CYCLES (S),
    .INPUT_CYCLES(I),
    .MAX_LIVES   (ML),
    .LEVELS      (L)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .btn_valid_i   (btn_valid),
    .btn_pattern_i (btn_pattern),
    .pat_addr_o    (pat_addr),
    .pat_data_i    (pat_data),
    .cmp_enable_o  (cmp_enable),
    .cmp_amp_o     (cmp_amp),
    .cmp_bmp_o     (cmp_bmp),
    .cmp_is_equal_i(cmp_is_equal),
    .led_o         (led),
    .level_o       (level),
    .lives_o       (lives),
    .busy_o        (busy),
    .result_valid_o(result_valid),
    .result_pass_o (result_pass),
    .game_won_o    (game_won),
    .game_over_o   (game_over)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  assign pat_data = mem[pat_addr];

  // Behavioural comparator: latches on the first enabled edge after an unlock and
  // reports the previously latched operands.
  logic        c_locked = 1'b0, c_has = 1'b0;
  logic [15:0] c_a = '0, c_b = '0;
  logic        c_eq = 1'b0;
  assign cmp_is_equal = c_eq;
  always @(posedge clk) begin
    if (cmp_enable && !c_locked) begin
      c_locked <= 1'b1;
      if (c_has) c_eq <= (c_a == c_b);
      c_a   <= cmp_amp;
      c_b   <= cmp_bmp;
      c_has <= 1'b1;
    end else if (!cmp_enable) begin
      c_locked <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       pass;
    logic [3:0] lvl;
    logic [1:0] lv;
    int         due;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: result_valid at cycle %0d, none expected", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_pass", 32'(result_pass), 32'(mon_e.pass));
        check("judge_level", 32'(level), 32'(mon_e.lvl));
        check("judge_lives", 32'(lives), 32'(mon_e.lv));
        check("result_latency", cyc, mon_e.due);
      end
    end
  end

  // Game-level model
  logic [3:0] m_level;
  logic [1:0] m_lives;
  bit         m_won, m_over, m_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at #1 after the edge that put the DUT into FETCH.
  // mode: 0 correct guess, 1 wrong guess, 2 timeout.
  task automatic play_round(input int mode, input int k, input bit spurious, input bit abort,
                            output bit aborted);
    logic [15:0] tgt, g;
    exp_t        e;
    logic [3:0]  en_seq;
    bit          led_ok, ops_ok, seen, p;
    int          c0;
    aborted = 1'b0;
    tgt     = mem[m_level];
    c0      = cyc;
    g       = tgt;
    if (mode == 1) g = tgt ^ (16'h1 << $urandom_range(15, 0));
    p      = (mode == 0);
    e.pass = p;
    e.lvl  = m_level;
    e.lv   = m_lives;
    e.due  = (mode == 2) ? c0 + S + I + 2 : c0 + S + k + 5;
    sb_q.push_back(e);

    @(negedge clk);
    led_ok = (led === 16'd0);
    tick();
    for (int i = 1; i <= S; i++) begin
      btn_valid   = spurious && (i == 2);
      start       = spurious && (i == 3);
      btn_pattern = ~tgt;
      @(negedge clk);
      if (led !== tgt) led_ok = 1'b0;
      tick();
    end
    btn_valid = 1'b0;
    start     = 1'b0;

    seen = 1'b0;
    if (mode == 2) begin
      for (int j = 1; j <= I + 1; j++) begin
        @(negedge clk);
        if (j == 1 && led !== 16'd0) led_ok = 1'b0;
        if (cmp_enable !== 1'b0) seen = 1'b1;
        tick();
      end
      check("timeout_no_cmp", 32'(seen), 32'd0);
    end else begin
      for (int j = 1; j <= k; j++) begin
        btn_valid   = (j == k);
        btn_pattern = (j == k) ? g : 16'($urandom);
        @(negedge clk);
        if (j == 1 && led !== 16'd0) led_ok = 1'b0;
        tick();
      end
      btn_valid = 1'b0;
      ops_ok    = 1'b1;
      for (int m = 0; m < 4; m++) begin
        if (abort && m == 2) begin
          rst_n = 1'b0;
          #1;
          check("rst_cmp_enable", 32'(cmp_enable), 32'd0);
          check("rst_outputs", {led, level, lives, busy, result_valid, result_pass, game_won,
                                game_over}, {16'd0, 4'd0, 2'(ML), 5'd0});
          check("rst_cmp_ops", {cmp_amp, cmp_bmp}, 32'd0);
          void'(sb_q.pop_back());
          m_level = 4'd0;
          m_lives = 2'(ML);
          aborted = 1'b1;
          return;
        end
        @(negedge clk);
        en_seq[3-m] = cmp_enable;
        if (cmp_amp !== tgt || cmp_bmp !== g) ops_ok = 1'b0;
        tick();
      end
      check("cmp_enable_seq", 32'(en_seq), 32'b1010);
      check("cmp_operands", 32'(ops_ok), 32'd1);
    end
    check("led_show", 32'(led_ok), 32'd1);

    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL result_wait: got no result_valid, expected one by cycle %0d", e.due);
    end
    tick();

    m_last = p;
    if (p) begin
      if (m_level == 4'(L - 1)) m_won = 1'b1;
      else m_level = m_level + 4'd1;
    end else if (m_lives == 2'd1) begin
      m_lives = 2'd0;
      m_over  = 1'b1;
    end else begin
      m_lives = m_lives - 2'd1;
    end
  endtask

  // policy: 0 all correct, 1 all wrong, 2 random
  task automatic play_game(input int policy, input int abort_round);
    int mode, k;
    bit ab;
    for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
    if (policy == 0) mem[0] = 16'hA5A5;
    if (policy == 1) mem[0] = 16'h00FF;
    start = 1'b1;
    tick();
    start   = 1'b0;
    m_level = 4'd0;
    m_lives = 2'(ML);
    m_won   = 1'b0;
    m_over  = 1'b0;
    m_last  = 1'b0;
    check("start_state", {level, lives, busy, result_pass}, {4'd0, 2'(ML), 1'b1, 1'b0});
    for (int r = 0; r < 40 && !m_won && !m_over; r++) begin
      if (policy == 0) mode = 0;
      else if (policy == 1) mode = 1;
      else begin
        mode = $urandom_range(3, 0);
        if (mode == 3) mode = 0;
      end
      if (r == abort_round) mode = 0;
      k = ($urandom_range(3, 0) == 0) ? I : $urandom_range(I, 1);
      play_round(mode, k, ($urandom_range(1, 0) == 1), (r == abort_round), ab);
      if (ab) return;
    end
    check("end_flags", {game_won, game_over, busy}, {m_won, m_over, 1'b0});
    check("end_level_lives", {level, lives}, {m_level, m_lives});
    check("end_result_pass", 32'(result_pass), 32'(m_last));
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    btn_valid   = 1'b0;
    btn_pattern = 16'd0;
    for (int a = 0; a < 16; a++) mem[a] = 16'd0;
    repeat (3) tick();
    check("reset_outputs", {led, level, lives, busy, result_valid, result_pass, game_won,
                            game_over}, {16'd0, 4'd0, 2'(ML), 5'd0});
    check("reset_cmp", {cmp_enable, pat_addr}, 5'd0);
    rst_n = 1'b1;
    tick();

    play_game(0, -1);
    play_game(1, -1);
    play_game(0, -1);
    for (int gm = 0; gm < 5; gm++) play_game(2, -1);
    play_game(2, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    play_game(0, -1);
    play_game(2, -1);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of run, expected finish");
    $fatal(1);
  end

endmodule
